// File: rtl/usr_op_sequencer.sv
// Command sequencer for a WIDTH-bit universal shift register: accepts LOAD, shift
// and rotate commands over valid/ready and drives the register's mode and data inputs.
module usr_op_sequencer #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] sr_q,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_parallel_in,
    output logic             sr_serial_left,
    output logic             sr_serial_right,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               fill_q, fill_d;

    // Only the end bits of sr_q feed the rotate path; the rest is intentionally unused.
    logic sr_q_unused;
    assign sr_q_unused = ^sr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            data_q  <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        fill_d  = fill_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    fill_d = cmd_fill;
                    cnt_d  = '0;
                    case (cmd_op)
                        OP_LOAD: state_d = ST_LOAD;
                        OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                            if (cmd_amt != '0) begin
                                state_d = ST_SHIFT;
                                cnt_d   = cmd_amt;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                        default: state_d = ST_DONE;
                    endcase
                end
            end
            ST_LOAD: state_d = ST_DONE;
            ST_SHIFT: begin
                // The counter holds the shifts still to perform, including this cycle's.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready       = (state_q == ST_IDLE);
        busy            = (state_q != ST_IDLE);
        done            = (state_q == ST_DONE);
        err             = (state_q == ST_DONE) && (op_q[2:1] == 2'b11);
        sr_mode         = MODE_HOLD;
        sr_parallel_in  = '0;
        sr_serial_left  = 1'b0;
        sr_serial_right = 1'b0;
        case (state_q)
            ST_LOAD: begin
                sr_mode        = MODE_LOAD;
                sr_parallel_in = data_q;
            end
            ST_SHIFT: begin
                case (op_q)
                    OP_SHL: begin
                        sr_mode         = MODE_SHL;
                        sr_serial_right = fill_q;
                    end
                    OP_SHR: begin
                        sr_mode        = MODE_SHR;
                        sr_serial_left = fill_q;
                    end
                    OP_ROL: begin
                        sr_mode         = MODE_SHL;
                        sr_serial_right = sr_q[WIDTH-1];
                    end
                    OP_ROR: begin
                        sr_mode        = MODE_SHR;
                        sr_serial_left = sr_q[0];
                    end
                    default: sr_mode = MODE_HOLD;
                endcase
            end
            default: sr_mode = MODE_HOLD;
        endcase
    end

endmodule

// File: tb/tb_usr_op_sequencer.sv
// Directed bench for usr_op_sequencer driving a behavioural 5-bit universal shift register.
module tb_usr_op_sequencer;

    localparam int WIDTH = 5;
    localparam int CNT_W = 3;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_fill;
    logic [WIDTH-1:0] sr_q;
    logic [1:0]       sr_mode;
    logic [WIDTH-1:0] sr_parallel_in;
    logic             sr_serial_left;
    logic             sr_serial_right;
    logic             busy;
    logic             done;
    logic             err;

    int passed;
    int total;
    int acc_cnt;
    int acc_base;

    usr_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_amt         (cmd_amt),
        .cmd_data        (cmd_data),
        .cmd_fill        (cmd_fill),
        .sr_q            (sr_q),
        .sr_mode         (sr_mode),
        .sr_parallel_in  (sr_parallel_in),
        .sr_serial_left  (sr_serial_left),
        .sr_serial_right (sr_serial_right),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    // Universal shift register the sequencer controls; shares the reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            case (sr_mode)
                2'b01:   sr_q <= {sr_q[WIDTH-2:0], sr_serial_right};
                2'b10:   sr_q <= {sr_serial_left, sr_q[WIDTH-1:1]};
                2'b11:   sr_q <= sr_parallel_in;
                default: sr_q <= sr_q;
            endcase
        end
    end

    always @(posedge clk) begin
        if (!reset && cmd_valid && cmd_ready) acc_cnt++;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [2:0] op, input logic [CNT_W-1:0] amt,
                        input logic [WIDTH-1:0] data, input logic fill);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = amt;
        cmd_data  = data;
        cmd_fill  = fill;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_amt   = '0;
        cmd_data  = '0;
        cmd_fill  = 1'b0;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        acc_cnt   = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_amt   = '0;
        cmd_data  = '0;
        cmd_fill  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_mode", sr_mode, 0);
        chk("rst_pin", sr_parallel_in, 0);
        chk("rst_sl", sr_serial_left, 0);
        chk("rst_sr", sr_serial_right, 0);
        chk("rst_q", sr_q, 0);

        // Reset in the middle of SHR N=7 fill=1
        send(3'b011, 3'd7, 5'b00000, 1'b1);
        chk("t1_busy", busy, 1);
        chk("t1_mode", sr_mode, 2'b10);
        chk("t1_sl", sr_serial_left, 1);
        tick();
        tick();
        chk("t1_q_mid", sr_q, 5'b11000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t1_busy_rst", busy, 0);
        chk("t1_ready_rst", cmd_ready, 1);
        chk("t1_mode_rst", sr_mode, 0);
        chk("t1_q_rst", sr_q, 0);
        chk("t1_done_rst", done, 0);
        tick();
        chk("t1_done_after", done, 0);
        chk("t1_busy_after", busy, 0);
        chk("t1_q_after", sr_q, 0);

        // LOAD 10110
        send(3'b001, 3'd0, 5'b10110, 1'b0);
        chk("t2_mode", sr_mode, 2'b11);
        chk("t2_pin", sr_parallel_in, 5'b10110);
        chk("t2_ready", cmd_ready, 0);
        chk("t2_done_early", done, 0);
        tick();
        chk("t2_done", done, 1);
        chk("t2_err", err, 0);
        chk("t2_mode_done", sr_mode, 0);
        chk("t2_q", sr_q, 5'b10110);
        tick();
        chk("t2_ready_back", cmd_ready, 1);
        chk("t2_done_gone", done, 0);

        // ROL N=2 from 10110
        send(3'b100, 3'd2, 5'b00000, 1'b0);
        chk("t3_mode", sr_mode, 2'b01);
        chk("t3_srin0", sr_serial_right, 1);
        tick();
        chk("t3_q1", sr_q, 5'b01101);
        chk("t3_srin1", sr_serial_right, 0);
        chk("t3_done_early", done, 0);
        tick();
        chk("t3_q2", sr_q, 5'b11010);
        chk("t3_done", done, 1);
        chk("t3_mode_done", sr_mode, 0);
        tick();
        chk("t3_q_hold", sr_q, 5'b11010);
        chk("t3_ready", cmd_ready, 1);

        // SHR N=3 fill=1 from 10110
        send(3'b001, 3'd0, 5'b10110, 1'b0);
        tick();
        tick();
        chk("t4_q_load", sr_q, 5'b10110);
        send(3'b011, 3'd3, 5'b00000, 1'b1);
        chk("t4_mode", sr_mode, 2'b10);
        tick();
        chk("t4_q1", sr_q, 5'b11011);
        chk("t4_done1", done, 0);
        tick();
        chk("t4_q2", sr_q, 5'b11101);
        chk("t4_done2", done, 0);
        tick();
        chk("t4_q3", sr_q, 5'b11110);
        chk("t4_done", done, 1);
        chk("t4_err", err, 0);
        tick();

        // SHL N=0, then illegal op 110
        send(3'b010, 3'd0, 5'b00000, 1'b1);
        chk("t5_shl0_done", done, 1);
        chk("t5_shl0_err", err, 0);
        chk("t5_shl0_q", sr_q, 5'b11110);
        chk("t5_shl0_mode", sr_mode, 0);
        tick();
        chk("t5_shl0_idle", cmd_ready, 1);
        send(3'b110, 3'd4, 5'b00000, 1'b0);
        chk("t5_ill_done", done, 1);
        chk("t5_ill_err", err, 1);
        chk("t5_ill_q", sr_q, 5'b11110);
        tick();
        chk("t5_ill_err_gone", err, 0);
        chk("t5_ill_done_gone", done, 0);

        // Back-pressure: LOAD held valid during SHL N=2 fill=0
        acc_base  = acc_cnt;
        cmd_valid = 1'b1;
        cmd_op    = 3'b010;
        cmd_amt   = 3'd2;
        cmd_fill  = 1'b0;
        tick();
        cmd_op    = 3'b001;
        cmd_amt   = 3'd5;
        cmd_data  = 5'b00101;
        chk("t6_ready0", cmd_ready, 0);
        tick();
        chk("t6_ready1", cmd_ready, 0);
        chk("t6_q1", sr_q, 5'b11100);
        tick();
        chk("t6_ready2", cmd_ready, 0);
        chk("t6_done", done, 1);
        chk("t6_q2", sr_q, 5'b11000);
        tick();
        chk("t6_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("t6_load_mode", sr_mode, 2'b11);
        chk("t6_load_pin", sr_parallel_in, 5'b00101);
        tick();
        chk("t6_load_done", done, 1);
        chk("t6_load_q", sr_q, 5'b00101);
        tick();
        tick();
        tick();
        chk("t6_accepts", acc_cnt - acc_base, 2);
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_q", sr_q, 5'b00101);

        // ROR N=1 from 00101; amount above WIDTH via ROR N=6
        send(3'b101, 3'd1, 5'b00000, 1'b0);
        chk("t7_sl", sr_serial_left, 1);
        tick();
        chk("t7_q", sr_q, 5'b10010);
        chk("t7_done", done, 1);
        tick();
        send(3'b101, 3'd6, 5'b00000, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        chk("t7_ror6_q", sr_q, 5'b01001);
        chk("t7_ror6_done", done, 1);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
